// File: rtl/udc_pkg.sv
// Shared types for the up/down counter primitive.
//   mode_e  : count mode encoding (2'b11 is reserved and behaves as wrap)
//   state_e : one-shot state machine encoding
//   PRESCALE_DEFAULT : default prescaler divide ratio
package udc_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10
   } mode_e;

   typedef enum logic {
      ST_RUN,
      ST_DONE
   } state_e;

   localparam int PRESCALE_DEFAULT = 4;

endpackage

// File: rtl/udc_prescaler.sv
// Prescaler for the up/down counter: emits a one-cycle tick on every
// PRESCALE-th cycle that has en high. Implemented as a down-counter that
// reloads on terminal count.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   clr  : synchronous clear (restarts the divide sequence)
//   en   : qualified cycle; counter holds while low
//   tick : combinational, high on the PRESCALE-th qualified cycle
module udc_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] ONE    = {{(CW-1){1'b0}}, 1'b1};

   logic [CW-1:0] cnt;

   assign tick = en & (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= RELOAD;
      end else if (en) begin
         cnt <= tick ? RELOAD : (cnt - ONE);
      end
   end

endmodule

// File: rtl/mod_updown_counter.sv
// N-bit synchronous up/down counter with programmable terminal value,
// wrap / saturate / one-shot modes and an active-low ripple-carry chain.
// Optional prescaler enabled by defining UDC_PRESCALE_EN.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset (highest priority)
//   en_b    : active-low count enable
//   load_b  : active-low synchronous load (needs en_b = 0)
//   up      : 1 = count up, 0 = count down
//   mode    : 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
//   load_in : load value, clamped to max_val
//   max_val : terminal value when counting up (range 0..max_val)
//   rci_b   : active-low ripple-carry in (tie 0 on the first stage)
//   q       : registered count
//   rco_b   : active-low ripple-carry out (combinational)
//   tc      : registered one-cycle terminal-count pulse
//   done    : high while the one-shot machine sits in DONE
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | counting allowed
// ST_DONE | one-shot finished; q frozen until load, rst or mode change
module mod_updown_counter
   import udc_pkg::*;
#(
   parameter int N        = 8,
   parameter int PRESCALE = PRESCALE_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_b,
   input  logic         load_b,
   input  logic         up,
   input  logic [1:0]   mode,
   input  logic [N-1:0] load_in,
   input  logic [N-1:0] max_val,
   input  logic         rci_b,
   output logic [N-1:0] q,
   output logic         rco_b,
   output logic         tc,
   output logic         done
);

   if (N < 2) begin : g_chk_n
      $error("mod_updown_counter: N must be at least 2");
   end
   if (PRESCALE < 1) begin : g_chk_prescale
      $error("mod_updown_counter: PRESCALE must be at least 1");
   end

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   logic [N-1:0] q_r;
   logic [N-1:0] step_val;
   logic [N-1:0] load_val;
   logic [N-1:0] term_val;
   logic         tc_q;
   logic         load;
   logic         qual;
   logic         tick;
   logic         step;
   logic         at_term;
   logic         is_run;
   state_e       state_q;
   state_e       state_d;

   assign load = ~en_b & ~load_b;
   assign qual = ~en_b & load_b & ~rci_b;

`ifdef UDC_PRESCALE_EN
   udc_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (load),
      .en   (qual),
      .tick (tick)
   );
`else
   assign tick = 1'b1;
`endif

   assign is_run   = (state_q == ST_RUN);
   assign step     = qual & tick & is_run;
   // q above max_val only happens after max_val shrinks; treat it as terminal
   // when counting up so the counter never runs off past the new range.
   assign at_term  = up ? (q_r >= max_val) : (q_r == '0);
   assign term_val = up ? max_val : '0;
   assign load_val = (load_in > max_val) ? max_val : load_in;

   always_comb begin
      step_val = q_r;
      if (!at_term) begin
         step_val = up ? (q_r + ONE) : (q_r - ONE);
      end else if (mode == MODE_SAT) begin
         step_val = (up && (q_r > max_val)) ? max_val : q_r;
      end else if (mode == MODE_ONESHOT) begin
         step_val = q_r;
      end else begin
         step_val = up ? '0 : max_val;
      end
   end

   always_comb begin
      state_d = state_q;
      rco_b   = ~(~en_b & ~rci_b & at_term & is_run & tick);
      if (load) begin
         state_d = ST_RUN;
      end else if ((state_q == ST_DONE) && (mode != MODE_ONESHOT)) begin
         state_d = ST_RUN;
      end else if (step && at_term && (mode == MODE_ONESHOT)) begin
         state_d = ST_DONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_r  <= '0;
         tc_q <= 1'b0;
      end else if (load) begin
         q_r  <= load_val;
         tc_q <= 1'b0;
      end else if (step) begin
         q_r  <= step_val;
         // Only a step that arrives at the terminal value pulses tc, so
         // holding at the terminal (saturate / one-shot) stays quiet.
         tc_q <= (step_val == term_val) && (q_r != term_val);
      end else begin
         tc_q <= 1'b0;
      end
   end

   assign q    = q_r;
   assign tc   = tc_q;
   assign done = (state_q == ST_DONE);

endmodule
